// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with multdiv scoreboard; optional bypass via REGFILE_BYPASS_EN
module regfile_sb #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int LED_REG = 9
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                ctrl_writeEnable,
  input  logic [AW-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]    data_writeReg,
  input  logic [AW-1:0]       ctrl_readRegA,
  input  logic [AW-1:0]       ctrl_readRegB,
  output logic [WIDTH-1:0]    data_readRegA,
  output logic [WIDTH-1:0]    data_readRegB,
  output logic                busy_A,
  output logic                busy_B,
  input  logic                md_issue,
  input  logic [AW-1:0]       md_issueReg,
  input  logic                md_valid,
  input  logic [AW-1:0]       md_reg,
  input  logic [WIDTH-1:0]    md_data,
  output logic                md_ready,
  output logic [(2**AW)-1:0]  pending,
  output logic                md_err,
  output logic [15:0]         LED
);

  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] regs [0:DEPTH-1];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             err_q;
  logic             prim_wr;
  logic             md_cmp;
  logic             md_iss;

  // Accepted-this-cycle strobes; address 0 is filtered so it never touches state.
  // The primary port blocks completion, so prim_wr and md_cmp never target the same register.
  assign prim_wr  = ctrl_writeEnable && (ctrl_writeReg != '0);
  assign md_ready = !prim_wr;
  assign md_cmp   = md_valid && md_ready && (md_reg != '0);
  assign md_iss   = md_issue && (md_issueReg != '0);

  // Next pending vector: completion clears, a same-cycle issue re-sets (new op wins).
  always_comb begin
    pending_d = pending_q;
    if (md_cmp) pending_d[md_reg] = 1'b0;
    if (md_iss) pending_d[md_issueReg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State update: reset dominates every concurrent write, issue and completion.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (prim_wr) regs[ctrl_writeReg] <= data_writeReg;
      if (md_cmp)  regs[md_reg]        <= md_data;
      pending_q <= pending_d;
      if (md_cmp && !pending_q[md_reg]) err_q <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read port A with same-cycle forwarding of accepted writes.
  always_comb begin
    data_readRegA = (ctrl_readRegA == '0) ? '0 : regs[ctrl_readRegA];
    if (md_cmp && md_reg == ctrl_readRegA) data_readRegA = md_data;
    if (prim_wr && ctrl_writeReg == ctrl_readRegA) data_readRegA = data_writeReg;
    busy_A = pending_q[ctrl_readRegA];
    if (md_cmp && md_reg == ctrl_readRegA && !(md_iss && md_issueReg == ctrl_readRegA))
      busy_A = 1'b0;
  end

  // Read port B with same-cycle forwarding of accepted writes.
  always_comb begin
    data_readRegB = (ctrl_readRegB == '0) ? '0 : regs[ctrl_readRegB];
    if (md_cmp && md_reg == ctrl_readRegB) data_readRegB = md_data;
    if (prim_wr && ctrl_writeReg == ctrl_readRegB) data_readRegB = data_writeReg;
    busy_B = pending_q[ctrl_readRegB];
    if (md_cmp && md_reg == ctrl_readRegB && !(md_iss && md_issueReg == ctrl_readRegB))
      busy_B = 1'b0;
  end
`else
  // Read port A straight from the array and registered pending bits.
  always_comb begin
    data_readRegA = (ctrl_readRegA == '0) ? '0 : regs[ctrl_readRegA];
    busy_A        = pending_q[ctrl_readRegA];
  end

  // Read port B straight from the array and registered pending bits.
  always_comb begin
    data_readRegB = (ctrl_readRegB == '0) ? '0 : regs[ctrl_readRegB];
    busy_B        = pending_q[ctrl_readRegB];
  end
`endif

  assign pending = pending_q;
  assign md_err  = err_q;
  assign LED     = regs[LED_REG][15:0];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        busy_A, busy_B;
  logic        md_issue;
  logic [4:0]  md_issueReg;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [31:0] pending;
  logic        md_err;
  logic [15:0] LED;

  int checks   = 0;
  int failures = 0;

  regfile_sb dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .busy_A(busy_A), .busy_B(busy_B),
    .md_issue(md_issue), .md_issueReg(md_issueReg),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .pending(pending), .md_err(md_err), .LED(LED)
  );

  always #5 clock = ~clock;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_reset = 0; ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
    md_issue = 0; md_issueReg = 0; md_valid = 0; md_reg = 0; md_data = 0;
  endtask

  task automatic test_reset();
    idle(); ctrl_readRegA = 5; ctrl_readRegB = 9;
    ctrl_reset = 1; cyc(); cyc(); ctrl_reset = 0; #1;
    checks++; if (data_readRegA !== 32'h0) begin failures++; $display("FAIL reset_rdA got=%h exp=0", data_readRegA); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if ({busy_A, busy_B, md_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy_A, busy_B, md_err}); end
    checks++; if (LED !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", LED); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL reset_md_ready got=%b exp=1", md_ready); end
  endtask

  task automatic test_primary_write();
    logic [31:0] exp_same;
    idle(); ctrl_writeEnable = 1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF; ctrl_readRegB = 5; #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    checks++; if (data_readRegB !== exp_same) begin failures++; $display("FAIL wr_same_cycle got=%h exp=%h", data_readRegB, exp_same); end
    cyc(); idle(); ctrl_readRegA = 5; #1;
    checks++; if (data_readRegA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_r5 got=%h exp=deadbeef", data_readRegA); end
    ctrl_writeEnable = 1; ctrl_writeReg = 0; data_writeReg = 32'h1234; #1;
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL wr_r0_ready got=%b exp=1", md_ready); end
    cyc(); idle(); ctrl_readRegA = 0; #1;
    checks++; if (data_readRegA !== 32'h0) begin failures++; $display("FAIL wr_r0 got=%h exp=0", data_readRegA); end
  endtask

  task automatic test_issue_complete();
    logic exp_busy;
    idle(); ctrl_readRegA = 7; md_issue = 1; md_issueReg = 7; #1;
    checks++; if (busy_A !== 1'b0) begin failures++; $display("FAIL iss_busy_before got=%b exp=0", busy_A); end
    cyc(); idle();
    checks++; if (pending !== 32'h80 || busy_A !== 1'b1) begin failures++; $display("FAIL iss_pending got=%h/%b exp=80/1", pending, busy_A); end
    md_valid = 1; md_reg = 7; md_data = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    checks++; if (md_ready !== 1'b1 || busy_A !== exp_busy) begin failures++; $display("FAIL cmp_cycle got=%b/%b exp=1/%b", md_ready, busy_A, exp_busy); end
    cyc(); idle();
    checks++; if (data_readRegA !== 32'h55 || pending !== 32'h0 || md_err !== 1'b0) begin failures++; $display("FAIL cmp_r7 got=%h/%h/%b exp=55/0/0", data_readRegA, pending, md_err); end
  endtask

  task automatic test_back_to_back();
    idle(); md_issue = 1; md_issueReg = 7; cyc(); idle();
    ctrl_writeEnable = 1; ctrl_writeReg = 3; data_writeReg = 32'h33;
    md_valid = 1; md_reg = 7; md_data = 32'h99; #1;
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL arb_blocked got=%b exp=0", md_ready); end
    cyc();
    checks++; if (pending !== 32'h80) begin failures++; $display("FAIL arb_still_pending got=%h exp=80", pending); end
    ctrl_writeEnable = 0; ctrl_writeReg = 0; #1;
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL arb_ready got=%b exp=1", md_ready); end
    cyc(); idle(); ctrl_readRegA = 7; ctrl_readRegB = 3; #1;
    checks++; if (data_readRegA !== 32'h99 || data_readRegB !== 32'h33) begin failures++; $display("FAIL arb_data got=%h/%h exp=99/33", data_readRegA, data_readRegB); end
    checks++; if (pending !== 32'h0 || md_err !== 1'b0) begin failures++; $display("FAIL arb_state got=%h/%b exp=0/0", pending, md_err); end
  endtask

  task automatic test_err();
    idle(); md_valid = 1; md_reg = 9; md_data = 32'hABCD; cyc(); idle();
    checks++; if (md_err !== 1'b1 || LED !== 16'hABCD) begin failures++; $display("FAIL err_set got=%b/%h exp=1/abcd", md_err, LED); end
    cyc(); cyc();
    checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", md_err); end
    ctrl_reset = 1; cyc(); ctrl_reset = 0; ctrl_readRegA = 9; #1;
    checks++; if (md_err !== 1'b0 || LED !== 16'h0 || data_readRegA !== 32'h0) begin failures++; $display("FAIL err_reset got=%b/%h/%h exp=0/0/0", md_err, LED, data_readRegA); end
  endtask

  task automatic test_same_cycle();
    idle(); md_issue = 1; md_issueReg = 4; cyc(); idle();
    ctrl_readRegA = 4; md_issue = 1; md_issueReg = 4; md_valid = 1; md_reg = 4; md_data = 32'h44; #1;
    checks++; if (busy_A !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", busy_A); end
    cyc(); idle(); md_issue = 1; md_issueReg = 6; #1;
    checks++; if (data_readRegA !== 32'h44 || pending !== 32'h10 || md_err !== 1'b0) begin failures++; $display("FAIL same_state got=%h/%h/%b exp=44/10/0", data_readRegA, pending, md_err); end
    cyc(); idle();
    checks++; if (pending !== 32'h50) begin failures++; $display("FAIL two_pending got=%h exp=50", pending); end
    ctrl_reset = 1; md_issue = 1; md_issueReg = 8; ctrl_writeEnable = 1; ctrl_writeReg = 4; data_writeReg = 32'hFF;
    cyc(); idle();
    checks++; if (pending !== 32'h0 || data_readRegA !== 32'h0) begin failures++; $display("FAIL reset_precedence got=%h/%h exp=0/0", pending, data_readRegA); end
  endtask

  task automatic test_reg0();
    idle(); ctrl_readRegA = 0; md_issue = 1; md_issueReg = 0; md_valid = 1; md_reg = 0; md_data = 32'h1;
    cyc(); idle();
    checks++; if (pending !== 32'h0 || md_err !== 1'b0 || data_readRegA !== 32'h0 || busy_A !== 1'b0) begin failures++; $display("FAIL reg0 got=%h/%b/%h/%b exp=0/0/0/0", pending, md_err, data_readRegA, busy_A); end
  endtask

  initial begin
    idle(); ctrl_readRegA = 0; ctrl_readRegB = 0;
    test_reset();
    test_primary_write();
    test_issue_complete();
    test_back_to_back();
    test_err();
    test_same_cycle();
    test_reg0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
